// File: rtl/remote_cmd_tx_if.sv
`default_nettype none
// ============================================================================
//  Module      : remote_cmd_tx_if
//  Description : Host-side command bus and UART transmit/receive handshake
//                bundle for the remote command transmitter.
//  Revision    : 1.0 - initial release
// ============================================================================
interface remote_cmd_tx_if #(
    parameter int NUM_BYTES = 2
) ();

    // host request side
    logic                   snd_cmd;
    logic [8*NUM_BYTES-1:0] cmd;
    logic                   busy;
    logic                   cmd_snt;
    logic [7:0]             resp;
    logic                   resp_vld;
    logic                   timeout;

    // UART side
    logic                   trmt;
    logic [7:0]             tx_data;
    logic                   tx_done;
    logic                   rx_rdy;
    logic [7:0]             rx_data;
    logic                   clr_rx_rdy;

    // transmitter view
    modport master (
        input  snd_cmd, cmd, tx_done, rx_rdy, rx_data,
        output trmt, tx_data, clr_rx_rdy, busy, cmd_snt, resp, resp_vld, timeout
    );

    // environment view (host controller + UART)
    modport slave (
        output snd_cmd, cmd, tx_done, rx_rdy, rx_data,
        input  trmt, tx_data, clr_rx_rdy, busy, cmd_snt, resp, resp_vld, timeout
    );

endinterface
`default_nettype wire

// File: rtl/remote_cmd_tx.sv
`default_nettype none
// ============================================================================
//  Module      : remote_cmd_tx
//  Description : Serialises a NUM_BYTES command onto a byte-wide UART transmit
//                handshake, then optionally waits (with timeout) for a single
//                response byte from the UART receiver.
//  Revision    : 1.0 - initial release
// ============================================================================
module remote_cmd_tx #(
    parameter int NUM_BYTES  = 2,
    parameter int MSB_FIRST  = 1,
    parameter int WAIT_RESP  = 1,
    parameter int TMO_CYCLES = 50000000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    remote_cmd_tx_if.master      bus
);

    localparam int CMD_W = 8 * NUM_BYTES;
    localparam int CNT_W = $clog2(NUM_BYTES) + 1;
    localparam int TMR_W = (TMO_CYCLES > 1) ? $clog2(TMO_CYCLES) : 1;

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_BYTES - 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TMO_CYCLES - 1);

    localparam logic [1:0] S_IDLE      = 2'd0;
    localparam logic [1:0] S_SEND      = 2'd1;
    localparam logic [1:0] S_WAIT_TX   = 2'd2;
    localparam logic [1:0] S_WAIT_RESP = 2'd3;

    logic [1:0]       state_q,    state_d;
    logic [CMD_W-1:0] shreg_q,    shreg_d;
    logic [CNT_W-1:0] cnt_q,      cnt_d;
    logic [TMR_W-1:0] timer_q,    timer_d;
    logic             trmt_q,     trmt_d;
    logic [7:0]       tx_data_q,  tx_data_d;
    logic             clr_q,      clr_d;
    logic             cmd_snt_q,  cmd_snt_d;
    logic [7:0]       resp_q,     resp_d;
    logic             resp_vld_q, resp_vld_d;
    logic             timeout_q,  timeout_d;

    logic [CMD_W-1:0] w_shreg_adv;   // shift register advanced by one byte
    logic [7:0]       w_cmd_byte;    // first byte to send, taken straight from cmd
    logic [7:0]       w_adv_byte;    // next byte to send after advancing
    logic             w_last_byte;
    logic             w_tmr_hit;

    // Byte order only changes which end of the shift register is consumed.
    generate
        if (MSB_FIRST != 0) begin : g_msb_first
            assign w_shreg_adv = shreg_q << 8;
            assign w_cmd_byte  = bus.cmd[CMD_W-1 -: 8];
            assign w_adv_byte  = w_shreg_adv[CMD_W-1 -: 8];
        end else begin : g_lsb_first
            assign w_shreg_adv = shreg_q >> 8;
            assign w_cmd_byte  = bus.cmd[7:0];
            assign w_adv_byte  = w_shreg_adv[7:0];
        end
    endgenerate

    assign w_last_byte = (cnt_q == LAST_IDX);
    assign w_tmr_hit   = (timer_q == TMR_LAST);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode; snd_cmd is only honoured in IDLE, tx_done only in WAIT_TX.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:      if (bus.snd_cmd) state_d = S_SEND;
            S_SEND:      state_d = S_WAIT_TX;
            S_WAIT_TX: begin
                if (bus.tx_done) begin
                    if (!w_last_byte)        state_d = S_SEND;
                    else if (WAIT_RESP != 0) state_d = S_WAIT_RESP;
                    else                     state_d = S_IDLE;
                end
            end
            S_WAIT_RESP: if (bus.rx_rdy || w_tmr_hit) state_d = S_IDLE;
            default:     state_d = S_IDLE;
        endcase
    end

    // Next values of the datapath and registered outputs; pulses default low.
    always_comb begin
        shreg_d    = shreg_q;
        cnt_d      = cnt_q;
        timer_d    = timer_q;
        trmt_d     = 1'b0;
        tx_data_d  = tx_data_q;
        clr_d      = 1'b0;
        cmd_snt_d  = cmd_snt_q;
        resp_d     = resp_q;
        resp_vld_d = 1'b0;
        timeout_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.snd_cmd) begin
                    shreg_d   = bus.cmd;
                    cnt_d     = '0;
                    cmd_snt_d = 1'b0;
                    trmt_d    = 1'b1;        // registered, so it is high in SEND
                    tx_data_d = w_cmd_byte;
                end
            end
            S_WAIT_TX: begin
                if (bus.tx_done) begin
                    if (w_last_byte) begin
                        cmd_snt_d = 1'b1;
                        timer_d   = '0;
                    end else begin
                        shreg_d   = w_shreg_adv;
                        cnt_d     = cnt_q + 1'b1;
                        trmt_d    = 1'b1;
                        tx_data_d = w_adv_byte;
                    end
                end
            end
            S_WAIT_RESP: begin
                // A pending byte beats an expiring timer in the same cycle.
                if (bus.rx_rdy) begin
                    resp_d     = bus.rx_data;
                    resp_vld_d = 1'b1;
                    clr_d      = 1'b1;
                end else if (w_tmr_hit) begin
                    timeout_d  = 1'b1;
                end else begin
                    timer_d    = timer_q + 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Datapath and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg_q    <= '0;
            cnt_q      <= '0;
            timer_q    <= '0;
            trmt_q     <= 1'b0;
            tx_data_q  <= 8'h00;
            clr_q      <= 1'b0;
            cmd_snt_q  <= 1'b0;
            resp_q     <= 8'h00;
            resp_vld_q <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            shreg_q    <= shreg_d;
            cnt_q      <= cnt_d;
            timer_q    <= timer_d;
            trmt_q     <= trmt_d;
            tx_data_q  <= tx_data_d;
            clr_q      <= clr_d;
            cmd_snt_q  <= cmd_snt_d;
            resp_q     <= resp_d;
            resp_vld_q <= resp_vld_d;
            timeout_q  <= timeout_d;
        end
    end

    assign bus.busy       = (state_q != S_IDLE);
    assign bus.trmt       = trmt_q;
    assign bus.tx_data    = tx_data_q;
    assign bus.clr_rx_rdy = clr_q;
    assign bus.cmd_snt    = cmd_snt_q;
    assign bus.resp       = resp_q;
    assign bus.resp_vld   = resp_vld_q;
    assign bus.timeout    = timeout_q;

endmodule
`default_nettype wire

// File: doc/remote_cmd_tx.md
Name: remote_cmd_tx

Overview:
- Parametrised command transmitter for the remote/host side of the tour link. It serialises a command of NUM_BYTES bytes onto a byte-wide UART transmit handshake.
- It then optionally waits for a one-byte response from the UART receiver, bounded by a timeout.
- It sits between the test/host controller and an external UART transceiver. It drives trmt/tx_data and consumes tx_done/rx_rdy/rx_data.

Parameters:
- NUM_BYTES, 2: command length in bytes; legal range 1..8.
- MSB_FIRST, 1: 1 sends the most significant byte first; 0 sends the least significant byte first.
- WAIT_RESP, 1: 1 waits for a response byte after the last byte is sent; 0 ends the command after the last tx_done.
- TMO_CYCLES, 50000000: response timeout in clk cycles; must be at least 2.

Ports:
- clk, input, 1: system clock; all state updates on posedge.
- rst_n, input, 1: asynchronous active-low reset.
- snd_cmd, input, 1: request to send cmd; sampled only in IDLE.
- cmd, input, 8*NUM_BYTES: command word; captured on an accepted snd_cmd.
- trmt, output, 1: one-cycle pulse to the UART to start transmitting tx_data.
- tx_data, output, 8: byte to transmit; valid from the trmt cycle until the matching tx_done.
- tx_done, input, 1: UART transmit-complete strobe.
- rx_rdy, input, 1: UART received byte available; level, held until cleared.
- rx_data, input, 8: received byte.
- clr_rx_rdy, output, 1: one-cycle pulse acknowledging the received byte.
- busy, output, 1: high in any state other than IDLE.
- cmd_snt, output, 1: set after the last byte's tx_done; cleared on the next accepted snd_cmd.
- resp, output, 8: last captured response byte.
- resp_vld, output, 1: one-cycle pulse when resp updates.
- timeout, output, 1: one-cycle pulse when the response wait expires.

Behaviour:
- Reset values: trmt=0, clr_rx_rdy=0, busy=0, cmd_snt=0, resp=8'h00, resp_vld=0, timeout=0, tx_data=8'h00; state=IDLE; byte counter=0; timer=0.
- States: IDLE, SEND, WAIT_TX, WAIT_RESP.
- IDLE:
  - snd_cmd high at edge k: cmd is copied into a shift register, byte counter cleared, cmd_snt cleared, state goes to SEND.
  - snd_cmd is ignored in every other state; the captured copy is unaffected by later changes on cmd.
- SEND (one cycle):
  - trmt=1.
  - tx_data = current byte: the top byte of the shift register when MSB_FIRST=1, the bottom byte when MSB_FIRST=0.
  - Next state WAIT_TX. trmt is therefore high in cycle k+1 after acceptance.
- WAIT_TX:
  - tx_data is held stable.
  - On tx_done with bytes remaining: shift register advances one byte, counter increments, next state SEND. Inter-byte gap is exactly one cycle after tx_done.
  - On tx_done for byte NUM_BYTES-1: cmd_snt goes high in the next cycle (set-dominant only over idle; an accepted snd_cmd resets it).
  - Then, if WAIT_RESP=1: timer is cleared and state goes to WAIT_RESP. If WAIT_RESP=0: state goes to IDLE.
- WAIT_RESP:
  - Timer increments each cycle.
  - rx_rdy high: resp<=rx_data, resp_vld and clr_rx_rdy pulse for one cycle, state goes to IDLE.
  - Else, when the timer reaches TMO_CYCLES-1: timeout pulses for one cycle, resp is unchanged, state goes to IDLE.
  - rx_rdy and the timer expiring in the same cycle: rx_rdy wins; no timeout pulse.
- rx_rdy asserted during SEND/WAIT_TX is not acknowledged. The byte is consumed on the first WAIT_RESP cycle if still pending.
- tx_done outside WAIT_TX is ignored.
- Timer width is clog2(TMO_CYCLES). Byte counter width is clog2(NUM_BYTES)+1. No wrap occurs in legal operation.
- NUM_BYTES=1: a single SEND/WAIT_TX pass.
- Reset asserted mid-command: immediate return to reset values. No partial resume; the next command starts from byte 0.
- busy is combinational from state; all other outputs are registered.

Test Plan:
- Default params, cmd=16'hA5C3, snd_cmd for 1 cycle, tx_done 10 cycles after each trmt -> trmt pulses with tx_data=8'hA5 then 8'hC3. cmd_snt is 0 until the cycle after the second tx_done, then 1. busy stays high until response or timeout.
- NUM_BYTES=4, MSB_FIRST=0, WAIT_RESP=0, cmd=32'h11223344 -> bytes 44,33,22,11 in order. Each trmt is exactly one cycle after the prior tx_done. Return to IDLE with cmd_snt=1 and no clr_rx_rdy.
- WAIT_RESP=1: rx_rdy with rx_data=8'hA5 arrives 20 cycles after the last tx_done -> resp=8'hA5, resp_vld and clr_rx_rdy each high one cycle, timeout never asserted.
- TMO_CYCLES=100, no rx_rdy -> timeout pulses exactly once, 100 cycles after entering WAIT_RESP; resp keeps its previous value. In a second run, rx_rdy is raised on the expiry cycle -> resp_vld, no timeout.
- snd_cmd re-pulsed with a different cmd while busy, plus a spurious tx_done in WAIT_RESP -> original bytes are sent unchanged and there is no extra trmt. cmd_snt is cleared only by the next snd_cmd accepted in IDLE.
- rst_n dropped between byte 0 and byte 1 -> all outputs return to reset values immediately. A subsequent command starts at byte 0 with correct order.
